// File: rtl/fnd_pkg.sv
// Shared constants, types and helpers for the FND scan controller.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Largest value four decimal digits can show; larger inputs are clamped.
  localparam logic [VALUE_W-1:0] MAX_VALUE = 14'd9999;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp stays dark here.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_LUT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_t;

  // Segment pattern for one BCD nibble; non-decimal codes read as blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
    if (nibble <= 4'd9) begin
      return SEG_LUT[nibble];
    end
    return SEG_BLANK;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets 3 added before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// A new load always restarts the conversion; only a conversion that reaches
// DONE undisturbed updates the committed BCD value and overflow flag.
module fnd_bin2bcd
  import fnd_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value_i,
  input  logic               load_i,
  output logic [BCD_W-1:0]   bcd_o,
  output logic               overflow_o,
  output logic               busy_o
);

  localparam int ITER_W = $clog2(VALUE_W);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VALUE_W - 1);

  conv_state_t        state_reg, state_next;
  logic [VALUE_W-1:0] bin_reg, bin_next;
  logic [BCD_W-1:0]   work_reg, work_next;
  logic [ITER_W-1:0]  iter_reg, iter_next;
  logic               ovf_pend_reg, ovf_pend_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic               ovf_reg, ovf_next;
  logic [BCD_W-1:0]   work_adj;

  assign work_adj = dd_adjust(work_reg);

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      work_reg     <= '0;
      iter_reg     <= '0;
      ovf_pend_reg <= 1'b0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      work_reg     <= work_next;
      iter_reg     <= iter_next;
      ovf_pend_reg <= ovf_pend_next;
      bcd_reg      <= bcd_next;
      ovf_reg      <= ovf_next;
    end
  end

  // Next-state logic: load has priority in every state (abort and restart).
  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    work_next     = work_reg;
    iter_next     = iter_reg;
    ovf_pend_next = ovf_pend_reg;
    bcd_next      = bcd_reg;
    ovf_next      = ovf_reg;

    if (load_i) begin
      if (value_i > MAX_VALUE) begin
        bin_next      = MAX_VALUE;
        ovf_pend_next = 1'b1;
      end else begin
        bin_next      = value_i;
        ovf_pend_next = 1'b0;
      end
      work_next  = '0;
      iter_next  = '0;
      state_next = CONV;
    end else begin
      case (state_reg)
        CONV: begin
          // Adjust then shift the combined {bcd, bin} register left by one.
          work_next = {work_adj[BCD_W-2:0], bin_reg[VALUE_W-1]};
          bin_next  = {bin_reg[VALUE_W-2:0], 1'b0};
          iter_next = iter_reg + ITER_W'(1);
          if (iter_reg == ITER_LAST) begin
            state_next = DONE;
          end
        end
        DONE: begin
          bcd_next   = work_reg;
          ovf_next   = ovf_pend_reg;
          state_next = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd_o      = bcd_reg;
  assign overflow_o = ovf_reg;
  assign busy_o     = (state_reg != IDLE);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller. Converts the loaded
// binary value to BCD, then time-multiplexes the digits with a prescaler.
// Digit select and segments come from one register stage so they never skew.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value_i,
  input  logic               load_i,
  input  logic               enable_i,
  input  logic [NUM_DIGITS-1:0] dp_i,
  input  logic               blank_lz_i,
  output logic [NUM_DIGITS-1:0] fnd_com_o,
  output logic [7:0]         fnd_seg_o,
  output logic               busy_o,
  output logic               overflow_o
);

  // Dwell length in clocks; must be at least 2.
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [BCD_W-1:0]      bcd;
  logic [PW-1:0]         presc_reg, presc_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [NUM_DIGITS-1:0] com_reg, com_next;
  logic [7:0]            seg_reg, seg_next;
  logic                  tick;
  logic [NUM_DIGITS-1:0][7:0] digit_seg;

  fnd_bin2bcd u_bin2bcd (
    .clock      (clock),
    .reset      (reset),
    .value_i    (value_i),
    .load_i     (load_i),
    .bcd_o      (bcd),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
  );

  // Per-digit segment pattern with leading-zero blanking and decimal point.
  // A digit is a leading zero when it and every higher digit are zero;
  // the ones digit always shows.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nibble;
      logic       blank;
      assign nibble = bcd[4*gi +: 4];
      if (gi == 0) begin : g_ones
        assign blank = 1'b0;
      end else begin : g_upper
        assign blank = blank_lz_i && (bcd[BCD_W-1:4*gi] == '0);
      end
      assign digit_seg[gi] = (blank ? SEG_BLANK : seg_decode(nibble))
                             & {~dp_i[gi], 7'h7F};
    end
  endgenerate

  // Prescaler, digit index and output register next values.
  always_comb begin
    tick       = (presc_reg == PRESC_LAST);
    presc_next = tick ? '0 : presc_reg + PW'(1);
    idx_next   = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
    end
    com_next = '1;
    seg_next = SEG_BLANK;
    if (enable_i) begin
      com_next = ~(NUM_DIGITS'(1) << idx_reg);
      seg_next = digit_seg[idx_reg];
    end
  end

  // Scan counters keep running while disabled; outputs registered together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
      idx_reg   <= '0;
      com_reg   <= '1;
      seg_reg   <= SEG_BLANK;
    end else begin
      presc_reg <= presc_next;
      idx_reg   <= idx_next;
      com_reg   <= com_next;
      seg_reg   <= seg_next;
    end
  end

  assign fnd_com_o = com_reg;
  assign fnd_seg_o = seg_reg;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: per-cycle reference model, a table
// of display vectors, hand sequences for restart/reset/disable, random phase.
module tb_fnd_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [13:0] value_i;
  logic        load_i;
  logic        enable_i;
  logic [3:0]  dp_i;
  logic        blank_lz_i;
  logic [3:0]  fnd_com_o;
  logic [7:0]  fnd_seg_o;
  logic        busy_o;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;

  // Reference model state (edge-counted, arithmetic view of the display).
  int   e_cnt;
  int   last_load;
  int   pend_val;
  logic pend_ovf;
  int   disp_val;
  logic disp_ovf;
  logic [3:0] exp_com;
  logic [7:0] exp_seg;
  logic exp_busy;
  logic exp_ovf;
  logic saw_92;

  logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    int          value;
    logic        blank;
    logic [3:0]  dp;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
    logic        ovf;
  } vec_t;

  vec_t vecs [11];

  fnd_scan_ctrl #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value_i    (value_i),
    .load_i     (load_i),
    .enable_i   (enable_i),
    .dp_i       (dp_i),
    .blank_lz_i (blank_lz_i),
    .fnd_com_o  (fnd_com_o),
    .fnd_seg_o  (fnd_seg_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  initial begin
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int v, input int d, input logic [3:0] dpm,
                                        input logic blk);
    int p;
    int digit;
    logic [7:0] s;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    digit = (v / p) % 10;
    s = (blk && d > 0 && v < p) ? 8'hFF : lut[digit];
    if (dpm[d]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    e_cnt     = 0;
    last_load = -100;
    pend_val  = 0;
    pend_ovf  = 1'b0;
    disp_val  = 0;
    disp_ovf  = 1'b0;
    exp_com   = 4'hF;
    exp_seg   = 8'hFF;
    exp_busy  = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  // One clock: update the model from the inputs sampled at the edge, then
  // compare every output on the falling edge.
  task automatic step();
    int idx;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      e_cnt++;
      idx = ((e_cnt - 1) / 10) % 4;
      if (enable_i) begin
        exp_com = ~(4'b0001 << idx);
        exp_seg = seg_of(disp_val, idx, dp_i, blank_lz_i);
      end else begin
        exp_com = 4'hF;
        exp_seg = 8'hFF;
      end
      if (load_i) begin
        last_load = e_cnt;
        pend_ovf  = (int'(value_i) > 9999);
        pend_val  = pend_ovf ? 9999 : int'(value_i);
      end else if (e_cnt == last_load + 15) begin
        disp_val = pend_val;
        disp_ovf = pend_ovf;
      end
      exp_busy = ((e_cnt - last_load) <= 14);
      exp_ovf  = disp_ovf;
    end
    @(negedge clock);
    chk("com", 32'(fnd_com_o), 32'(exp_com));
    chk("seg", 32'(fnd_seg_o), 32'(exp_seg));
    chk("busy", 32'(busy_o), 32'(exp_busy));
    chk("overflow", 32'(overflow_o), 32'(exp_ovf));
    if (fnd_com_o == 4'b1110 && fnd_seg_o == 8'h92) saw_92 = 1'b1;
  endtask

  task automatic do_load(input int v);
    load_i  = 1'b1;
    value_i = 14'(v);
    $display("load value=%0d blank=%0b dp=%b en=%0b", v, blank_lz_i, dp_i, enable_i);
    step();
    load_i = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_o) break;
      n++;
      step();
    end
  endtask

  task automatic capture(output logic [31:0] segs);
    segs = 32'hxxxxxxxx;
    for (int i = 0; i < 40; i++) begin
      step();
      case (fnd_com_o)
        4'b1110: segs[7:0]   = fnd_seg_o;
        4'b1101: segs[15:8]  = fnd_seg_o;
        4'b1011: segs[23:16] = fnd_seg_o;
        4'b0111: segs[31:24] = fnd_seg_o;
        default: begin
        end
      endcase
    end
  endtask

  initial begin
    int n;
    int n_pre;
    logic [31:0] segs;
    logic found;

    vecs[0]  = '{1234,  1'b0, 4'b0000, 32'hF9A4B099, 1'b0};
    vecs[1]  = '{12000, 1'b0, 4'b0000, 32'h90909090, 1'b1};
    vecs[2]  = '{5,     1'b0, 4'b0000, 32'hC0C0C092, 1'b0};
    vecs[3]  = '{7,     1'b1, 4'b0000, 32'hFFFFFFF8, 1'b0};
    vecs[4]  = '{7,     1'b0, 4'b0000, 32'hC0C0C0F8, 1'b0};
    vecs[5]  = '{7,     1'b1, 4'b0010, 32'hFFFF7FF8, 1'b0};
    vecs[6]  = '{0,     1'b1, 4'b0000, 32'hFFFFFFC0, 1'b0};
    vecs[7]  = '{1000,  1'b1, 4'b0001, 32'hF9C0C040, 1'b0};
    vecs[8]  = '{9999,  1'b0, 4'b0000, 32'h90909090, 1'b0};
    vecs[9]  = '{10000, 1'b0, 4'b0000, 32'h90909090, 1'b1};
    vecs[10] = '{8081,  1'b1, 4'b1000, 32'h00C080F9, 1'b0};

    saw_92     = 1'b0;
    reset      = 1'b1;
    load_i     = 1'b0;
    value_i    = '0;
    enable_i   = 1'b1;
    dp_i       = 4'b0000;
    blank_lz_i = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b0;

    // Table-driven display vectors.
    for (int v = 0; v < 11; v++) begin
      blank_lz_i = vecs[v].blank;
      dp_i       = vecs[v].dp;
      do_load(vecs[v].value);
      measure_busy(n);
      chk("busy_len", 32'(n), 32'd15);
      capture(segs);
      chk("digits", segs, vecs[v].segs);
      chk("ovf_flag", 32'(overflow_o), 32'(vecs[v].ovf));
    end

    // Reset in the middle of a conversion.
    blank_lz_i = 1'b0;
    dp_i       = 4'b0000;
    do_load(9999);
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    #1;
    chk("rst_com", 32'(fnd_com_o), 32'hF);
    chk("rst_seg", 32'(fnd_seg_o), 32'hFF);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    step();
    step();
    reset = 1'b0;
    capture(segs);
    chk("after_rst", segs, 32'hC0C0C0C0);

    // Restart: load 5 then 42 three cycles later; 5 must never be shown.
    saw_92 = 1'b0;
    do_load(5);
    n_pre = busy_o ? 1 : 0;
    step();
    n_pre += busy_o ? 1 : 0;
    step();
    n_pre += busy_o ? 1 : 0;
    do_load(42);
    measure_busy(n);
    chk("restart_busy", 32'(n_pre + n), 32'd18);
    capture(segs);
    chk("restart_val", segs, 32'hC0C099A4);
    chk("restart_no5", 32'(saw_92), 32'd0);

    // Disable while digit2 is selected, then re-enable.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (fnd_com_o == 4'b1011) found = 1'b1;
      else step();
    end
    chk("find_digit2", 32'(found), 32'd1);
    enable_i = 1'b0;
    step();
    chk("dis_com", 32'(fnd_com_o), 32'hF);
    chk("dis_seg", 32'(fnd_seg_o), 32'hFF);
    for (int i = 0; i < 5; i++) step();
    enable_i = 1'b1;
    step();
    chk("reen_active", 32'(fnd_com_o != 4'hF), 32'd1);
    chk("reen_busy", 32'(busy_o), 32'd0);

    // Random phase against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 29) == 0) dp_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) blank_lz_i = ~blank_lz_i;
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 16383)));
        else do_load(int'($urandom_range(0, 9999)));
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Display back-end for the FND counter peripheral. It sits directly downstream of the AXI4-Lite register file and consumes its four 32-bit slave registers: value, control, decimal-point mask and blanking. It converts the binary count to BCD with a sequential double-dabble engine and time-multiplexes four common-anode 7-segment digits with active-low segment and common lines.

## Interface
- `CLK_HZ`, 100_000_000, clock frequency in Hz.
- `SCAN_HZ`, 1000, per-digit dwell rate. Digit advances every `CLK_HZ/SCAN_HZ` cycles; the quotient must be ≥ 2.
- `clock`  in  1  single clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `value_i`  in  14  binary value to display, taken from slv_reg0[13:0].
- `load_i`  in  1  one-cycle strobe; register-file write to slv_reg0.
- `enable_i`  in  1  display enable, from slv_reg1[0].
- `dp_i`  in  4  decimal point per digit, from slv_reg2[3:0]; 1 lights the point; bit0 is the ones digit.
- `blank_lz_i`  in  1  leading-zero blanking, from slv_reg3[0].
- `fnd_com_o`  out  4  digit select, active-low; bit0 is the ones digit.
- `fnd_seg_o`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- `busy_o`  out  1  conversion in progress.
- `overflow_o`  out  1  last committed value was > 9999.

## Operation
- Reset values:
  - `fnd_com_o` = 4'b1111, `fnd_seg_o` = 8'hFF.
  - `busy_o` = 0, `overflow_o` = 0.
  - Committed BCD = 0000, digit index = 0, prescaler = 0, FSM = IDLE.
- Conversion FSM:
  - IDLE: on `load_i`, latch `value_i` and go to CONV. Any input above 9999 is clamped to 9999 and the overflow bit is latched.
  - CONV: 14 iterations of double-dabble, one bit per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left. After the 14th iteration go to DONE.
  - DONE: commit the four BCD nibbles and the overflow bit to the display registers, then return to IDLE.
- `load_i` during CONV or DONE aborts the current conversion and restarts from the new value. Only completed conversions are ever committed.
- Scan:
  - The prescaler counts 0 .. `CLK_HZ/SCAN_HZ`-1. Terminal count produces a tick.
  - A tick advances the digit index 0→1→2→3→0.
  - The prescaler and index keep running while `enable_i` = 0.
- Segment output for the current digit: LUT of the BCD nibble; bit7 is cleared when the matching `dp_i` bit is 1.
- Leading-zero blanking: with `blank_lz_i` = 1, a digit reads as blank (8'hFF before dp) if it and every higher digit are 0. Digit 0 is never blanked.
- `enable_i` = 0 forces `fnd_com_o` = 1111 and `fnd_seg_o` = FF.

## Timing
- `load_i` sampled at edge N:
  - `busy_o` is high for cycles N+1 .. N+15.
  - The committed value appears at `fnd_seg_o` from N+16 whenever its digit is selected.
- `fnd_com_o` and `fnd_seg_o` are registered together. Both change on the edge after the tick, or after a commit, enable change or dp/blank change, with no skew between them.
- `enable_i` falling is reflected one cycle later.
- `overflow_o` updates at commit, in the same cycle as the BCD registers.
- Reset asserted mid-conversion returns every output to its reset value asynchronously. A conversion in flight is discarded.

## Structure
- Package `fnd_pkg`:
  - `NUM_DIGITS` = 4, `MAX_VALUE` = 9999.
  - `SEG_LUT[0:9]` = C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - `SEG_BLANK` = FF.
  - FSM state enum {IDLE, CONV, DONE}.
- Sub-module `fnd_bin2bcd`: sequential double-dabble holding the FSM, `busy_o` and the abort/restart logic. The top level holds the prescaler, scan mux, blanking and output registers.

## Test plan
All scenarios use `CLK_HZ` = 1000 and `SCAN_HZ` = 100, giving 10 cycles per digit.
- Basic display: `load_i` with 1234, `enable_i` = 1.
  - `busy_o` is high for exactly 15 cycles.
  - The `fnd_com_o` sequence 1110/1101/1011/0111 pairs with `fnd_seg_o` 99/B0/A4/F9.
- Overflow: load 12000 → `overflow_o` = 1 and all four digits show 90. A later load of 5 clears `overflow_o` at its commit.
- Leading-zero blanking: load 7 with `blank_lz_i` = 1 → digit0 F8, digits 1-3 FF. With `blank_lz_i` = 0 → digits 1-3 show C0. With `dp_i` = 0010 and value 7 → digit1 shows 7F.
- Restart: load 5, then load 42 three cycles later.
  - `busy_o` stays high continuously until 15 cycles after the second load.
  - The display goes 0000 → 0042; 0005 never appears.
- Reset mid-conversion: assert `reset` 6 cycles after loading 9999.
  - Outputs immediately read 1111/FF with `busy_o` = 0.
  - After release with `enable_i` = 1, the display shows 0000 (C0).
- Disable: drop `enable_i` while digit2 is selected → next cycle 1111/FF. Re-enable → scan resumes at the current index with no reload.
